rv32_muldiv_ctrl: RTL

Multi-cycle M-extension execution unit with its own sequencer. It sits in the execute stage beside the integer ALU and serves every instruction the decoder routes to the multiply/divide writeback source. It accepts one request at a time over a valid/ready handshake and runs an iterative shift-add multiply or restoring divide. It holds the result until writeback takes it, and the pipeline stalls on req_ready/resp_valid.

---
 rtl/rv32_types.sv | 23 ++
 rtl/rv32_muldiv_core.sv | 46 ++++
 rtl/rv32_muldiv_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rv32_types.sv
// rv32_types: shared op/state encodings and constants for the M-extension unit.
package rv32_types;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/rv32_muldiv_core.sv
// rv32_muldiv_core: hi/lo/divisor registers and one shift-add (multiply) or restoring-subtract (divide) step per cycle.
module rv32_muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [XLEN:0]   sum, sh;
    logic            ge;

    // One iteration: multiply adds b into hi when lo[0] is set then shifts right;
    // divide shifts the remainder left and keeps the subtraction when it fits.
    always_comb begin
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        sh     = {hi_q, lo_q[XLEN-1]};
        ge     = sh >= {1'b0, b_q};
        hi_nxt = is_div ? (ge ? sh[XLEN-1:0] - b_q : sh[XLEN-1:0]) : sum[XLEN:1];
        lo_nxt = is_div ? {lo_q[XLEN-2:0], ge} : {sum[0], lo_q[XLEN-1:1]};
        hi_d   = load ? '0 : step ? hi_nxt : hi_q;
        lo_d   = load ? a : step ? lo_nxt : lo_q;
        b_d    = load ? b : b_q;
    end

    // Accumulator / remainder state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

endmodule

// File: rtl/rv32_muldiv_ctrl.sv
// rv32_muldiv_ctrl: M-extension sequencer (handshake, special cases, sign fix-up); RV32_FAST_MUL_EN selects a single-cycle multiplier.
import rv32_types::*;

module rv32_muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_in, op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              busy_q, busy_d;

    logic              a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic              div_zero, ovf, fast, accept;
    logic [XLEN-1:0]   a_mag, b_mag, fast_data, hi_nxt, lo_nxt, fin;
    logic [2*XLEN-1:0] v, f;

    assign op_in  = muldiv_op_t'(req_op);
    assign accept = (state_q == IDLE) && req_valid && !flush;

`ifdef RV32_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fm_p;
    logic [XLEN-1:0]          fm_data;

    // Single-cycle 33x33 signed product; the extra top bit carries each operand's signedness.
    always_comb begin
        fm_p    = $signed({a_sgn & req_rs1[XLEN-1], req_rs1}) * $signed({b_sgn & req_rs2[XLEN-1], req_rs2});
        fm_data = (op_in == MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    end
`endif

    // Operand conditioning and the cases that skip iteration.
    always_comb begin
        a_sgn     = (op_in != MULHU) && (op_in != DIVU) && (op_in != REMU);
        b_sgn     = a_sgn && (op_in != MULHSU);
        a_neg     = a_sgn && req_rs1[XLEN-1];
        b_neg     = b_sgn && req_rs2[XLEN-1];
        a_mag     = a_neg ? -req_rs1 : req_rs1;
        b_mag     = b_neg ? -req_rs2 : req_rs2;
        neg_in    = (op_in == REM) ? a_neg : a_neg ^ b_neg;
        div_zero  = op_in[2] && (req_rs2 == '0);
        ovf       = ((op_in == DIV) || (op_in == REM)) && (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
        fast_data = div_zero ? (op_in[1] ? req_rs1 : DIV_BY_ZERO_Q) : (op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
`ifdef RV32_FAST_MUL_EN
        fast      = div_zero || ovf || !op_in[2];
        fast_data = op_in[2] ? fast_data : fm_data;
`else
        fast      = div_zero || ovf;
`endif
    end

    // Final sign fix-up on the last step's output: negate the 64-bit product or the quotient/remainder.
    always_comb begin
        v   = op_q[2] ? {{XLEN{1'b0}}, op_q[1] ? hi_nxt : lo_nxt} : {hi_nxt, lo_nxt};
        f   = neg_q ? -v : v;
        fin = (op_q[2] || (op_q == MUL)) ? f[XLEN-1:0] : f[2*XLEN-1:XLEN];
    end

    // Next-state logic; flush overrides every transition and drops any request in the same cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        data_d  = data_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    op_d    = op_in;
                    neg_d   = neg_in;
                    state_d = fast ? DONE : CALC;
                    cnt_d   = fast ? cnt_q : CNT_W'(XLEN - 1);
                    data_d  = fast ? fast_data : data_q;
                end
                CALC: begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == '0) ? DONE : CALC;
                    data_d  = (cnt_q == '0) ? fin : data_q;
                end
                DONE:    state_d = resp_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
        req_ready_d  = state_d == IDLE;
        resp_valid_d = state_d == DONE;
        busy_d       = state_d != IDLE;
    end

    // FSM state, latched request context and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= MUL;
            cnt_q        <= '0;
            neg_q        <= 1'b0;
            data_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            neg_q        <= neg_d;
            data_q       <= data_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = data_q;
    assign busy       = busy_q;

    rv32_muldiv_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state_q == CALC),
        .is_div (op_q[2]),
        .a      (a_mag),
        .b      (b_mag),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

endmodule
